// File: rtl/spu_event_arbiter.sv
// Buffers one-cycle event pulses from the SPU AXI channel monitors in per-channel FIFOs and
// serializes them onto a single valid/ready event stream, counting any events that overflow.
module spu_event_arbiter #(
  parameter int NUM_CH          = 5,
  parameter int EVENT_ID_BITS   = 3,
  parameter int EVENT_INFO_BITS = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int DROP_CNT_BITS   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              prio_mode_i,
  input  logic [NUM_CH-1:0]                 ev_valid_i,
  input  logic [NUM_CH*EVENT_INFO_BITS-1:0] ev_info_i,
  output logic                              e_valid_o,
  input  logic                              e_ready_i,
  output logic [EVENT_ID_BITS-1:0]          e_id_o,
  output logic [EVENT_INFO_BITS-1:0]        e_info_o,
  output logic [NUM_CH-1:0]                 ovf_o,
  output logic [DROP_CNT_BITS-1:0]          drop_cnt_o,
  input  logic                              clr_stats_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [EVENT_INFO_BITS-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [EVENT_INFO_BITS-1:0] mem_d [NUM_CH][FIFO_DEPTH];
  logic [PTR_W:0]             rd_ptr_q [NUM_CH];
  logic [PTR_W:0]             rd_ptr_d [NUM_CH];
  logic [PTR_W:0]             wr_ptr_q [NUM_CH];
  logic [PTR_W:0]             wr_ptr_d [NUM_CH];

  logic [CH_W-1:0]            rr_q, rr_d;
  logic                       e_valid_q, e_valid_d;
  logic [EVENT_ID_BITS-1:0]   e_id_q, e_id_d;
  logic [EVENT_INFO_BITS-1:0] e_info_q, e_info_d;
  logic [NUM_CH-1:0]          ovf_q, ovf_d;
  logic [DROP_CNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;

  logic [NUM_CH-1:0]          non_empty, full, push_req, pop, drop;
  logic                       load_en, grant_valid;
  logic [CH_W-1:0]            grant_idx;
  logic [DROP_CNT_BITS:0]     drop_sum;
  int                         rr_idx;

  // An extra wrap bit on each pointer distinguishes full from empty.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      non_empty[c] = (rd_ptr_q[c] != wr_ptr_q[c]);
      full[c]      = (rd_ptr_q[c][PTR_W] != wr_ptr_q[c][PTR_W]) &&
                     (rd_ptr_q[c][PTR_W-1:0] == wr_ptr_q[c][PTR_W-1:0]);
      push_req[c]  = enable_i && ev_valid_i[c];
    end
  end

  assign load_en = !e_valid_q || e_ready_i;

  // Descending loops let the lowest index (or smallest round-robin offset) win.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    if (prio_mode_i) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (non_empty[c]) begin
          grant_valid = 1'b1;
          grant_idx   = CH_W'(c);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        rr_idx = int'(rr_q) + i;
        if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
        if (non_empty[rr_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = CH_W'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]  = load_en && grant_valid && (grant_idx == CH_W'(c));
      drop[c] = push_req[c] && full[c] && !pop[c];
      if (pop[c]) rd_ptr_d[c] = rd_ptr_q[c] + (PTR_W + 1)'(1);
      if (push_req[c] && !drop[c]) begin
        mem_d[c][wr_ptr_q[c][PTR_W-1:0]] = ev_info_i[c*EVENT_INFO_BITS +: EVENT_INFO_BITS];
        wr_ptr_d[c] = wr_ptr_q[c] + (PTR_W + 1)'(1);
      end
    end
  end

  // Carry into the extra top bit marks saturation; at most NUM_CH is added per cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int c = 0; c < NUM_CH; c++) begin
      if (drop[c]) drop_sum = drop_sum + (DROP_CNT_BITS + 1)'(1);
    end
    drop_cnt_d = drop_sum[DROP_CNT_BITS] ? '1 : drop_sum[DROP_CNT_BITS-1:0];
    ovf_d      = ovf_q | drop;
    if (clr_stats_i) begin
      drop_cnt_d = '0;
      ovf_d      = '0;
    end
  end

  always_comb begin
    e_valid_d = e_valid_q;
    e_id_d    = e_id_q;
    e_info_d  = e_info_q;
    rr_d      = rr_q;
    if (load_en) begin
      e_valid_d = grant_valid;
      if (grant_valid) begin
        e_id_d   = EVENT_ID_BITS'(grant_idx) + EVENT_ID_BITS'(1);
        e_info_d = mem_q[grant_idx][rd_ptr_q[grant_idx][PTR_W-1:0]];
        if (!prio_mode_i) begin
          rr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
      end
      rr_q       <= '0;
      e_valid_q  <= 1'b0;
      e_id_q     <= '0;
      e_info_q   <= '0;
      ovf_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rr_q       <= rr_d;
      e_valid_q  <= e_valid_d;
      e_id_q     <= e_id_d;
      e_info_q   <= e_info_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign e_valid_o  = e_valid_q;
  assign e_id_o     = e_id_q;
  assign e_info_o   = e_info_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_spu_event_arbiter.sv
// Scoreboard bench for spu_event_arbiter: expected events are queued as stimulus is driven
// and compared in order at every output handshake; scenario tasks add their own inline checks.
module tb_spu_event_arbiter;

  localparam int NUM_CH = 5;
  localparam int IDW    = 3;
  localparam int INFW   = 8;
  localparam int DEPTH  = 4;
  localparam int DCW    = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   prio_mode;
  logic [NUM_CH-1:0]      ev_valid;
  logic [NUM_CH*INFW-1:0] ev_info;
  logic                   e_valid;
  logic                   e_ready;
  logic [IDW-1:0]         e_id;
  logic [INFW-1:0]        e_info;
  logic [NUM_CH-1:0]      ovf;
  logic [DCW-1:0]         drop_cnt;
  logic                   clr_stats;

  int checks_total  = 0;
  int checks_passed = 0;
  int hs_cnt        = 0;
  logic [IDW+INFW-1:0] exp_q[$];

  spu_event_arbiter #(
    .NUM_CH(NUM_CH), .EVENT_ID_BITS(IDW), .EVENT_INFO_BITS(INFW),
    .FIFO_DEPTH(DEPTH), .DROP_CNT_BITS(DCW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .prio_mode_i(prio_mode),
    .ev_valid_i(ev_valid), .ev_info_i(ev_info), .e_valid_o(e_valid),
    .e_ready_i(e_ready), .e_id_o(e_id), .e_info_o(e_info), .ovf_o(ovf),
    .drop_cnt_o(drop_cnt), .clr_stats_i(clr_stats)
  );

  always #5 clk = ~clk;

  // Scoreboard: each handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [IDW+INFW-1:0] exp_v;
    if (!rst && e_valid && e_ready) begin
      hs_cnt++;
      checks_total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL scoreboard_unexpected: got id=%0d info=%02h, expected no event", e_id, e_info);
      end else begin
        exp_v = exp_q.pop_front();
        if ({e_id, e_info} !== exp_v)
          $display("[TB] FAIL scoreboard: got id=%0d info=%02h, expected id=%0d info=%02h",
                   e_id, e_info, exp_v[IDW+INFW-1:INFW], exp_v[INFW-1:0]);
        else checks_passed++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    tick();
  endtask

  task automatic set_ev(input int ch, input logic [INFW-1:0] info);
    ev_valid[ch]             = 1'b1;
    ev_info[ch*INFW +: INFW] = info;
  endtask

  task automatic clear_ev();
    ev_valid = '0;
    ev_info  = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b1;
    prio_mode = 1'b0;
    e_ready   = 1'b0;
    clr_stats = 1'b0;
    clear_ev();
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks_total++;
    if (e_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", e_valid);
    else checks_passed++;
    checks_total++;
    if (e_id !== 3'd0 || e_info !== 8'h00)
      $display("[TB] FAIL reset_id_info: got id=%0d info=%02h expected 0/00", e_id, e_info);
    else checks_passed++;
    checks_total++;
    if (ovf !== 5'b0 || drop_cnt !== 16'd0)
      $display("[TB] FAIL reset_stats: got ovf=%05b cnt=%0d expected 0/0", ovf, drop_cnt);
    else checks_passed++;
  endtask

  task automatic test_single();
    do_reset();
    e_ready = 1'b1;
    exp_q.push_back({3'd3, 8'h30});
    set_ev(2, 8'h30);
    tick();
    clear_ev();
    checks_total++;
    if (e_valid !== 1'b0) $display("[TB] FAIL single_latency: got valid=%0b expected 0", e_valid);
    else checks_passed++;
    tick();
    checks_total++;
    if (e_valid !== 1'b1 || e_id !== 3'd3 || e_info !== 8'h30)
      $display("[TB] FAIL single_out: got v=%0b id=%0d info=%02h expected 1/3/30", e_valid, e_id, e_info);
    else checks_passed++;
    tick();
    checks_total++;
    if (e_valid !== 1'b0) $display("[TB] FAIL single_deassert: got valid=%0b expected 0", e_valid);
    else checks_passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    e_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        exp_q.push_back({IDW'(c + 1), INFW'(8'h40 + 8'(16 * b) + 8'(c))});
        set_ev(c, INFW'(8'h40 + 8'(16 * b) + 8'(c)));
      end
      tick();
      clear_ev();
      for (int i = 0; i < NUM_CH; i++) begin
        tick();
        checks_total++;
        if (e_valid !== 1'b1 || e_id !== IDW'(i + 1))
          $display("[TB] FAIL rr_order: burst %0d slot %0d got v=%0b id=%0d expected 1/%0d",
                   b, i, e_valid, e_id, i + 1);
        else checks_passed++;
      end
      tick();
    end
    checks_total++;
    if (exp_q.size() != 0) $display("[TB] FAIL rr_drain: got %0d pending expected 0", exp_q.size());
    else checks_passed++;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    prio_mode = 1'b1;
    e_ready   = 1'b1;
    exp_q.push_back({3'd1, 8'h20});
    exp_q.push_back({3'd2, 8'h21});
    exp_q.push_back({3'd1, 8'h2F});
    exp_q.push_back({3'd3, 8'h22});
    exp_q.push_back({3'd4, 8'h23});
    exp_q.push_back({3'd5, 8'h24});
    for (int c = 0; c < NUM_CH; c++) set_ev(c, INFW'(8'h20 + 8'(c)));
    tick();
    clear_ev();
    tick();
    set_ev(0, 8'h2F);
    tick();
    clear_ev();
    tick();
    checks_total++;
    if (e_valid !== 1'b1 || e_id !== 3'd1 || e_info !== 8'h2F)
      $display("[TB] FAIL prio_preempt: got v=%0b id=%0d info=%02h expected 1/1/2F", e_valid, e_id, e_info);
    else checks_passed++;
    wait_drain(20);
    checks_total++;
    if (exp_q.size() != 0) $display("[TB] FAIL prio_drain: got %0d pending expected 0", exp_q.size());
    else checks_passed++;
    prio_mode = 1'b0;
  endtask

  task automatic test_overflow();
    int hs0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back({3'd2, INFW'(8'h10 + 8'(i))});
      set_ev(1, INFW'(8'h10 + 8'(i)));
      tick();
    end
    clear_ev();
    checks_total++;
    if (ovf !== 5'b00010) $display("[TB] FAIL ovf_flag: got %05b expected 00010", ovf);
    else checks_passed++;
    checks_total++;
    if (drop_cnt !== 16'd1) $display("[TB] FAIL ovf_count: got %0d expected 1", drop_cnt);
    else checks_passed++;
    hs0 = hs_cnt;
    e_ready = 1'b1;
    wait_drain(20);
    tick();
    checks_total++;
    if (hs_cnt - hs0 != 5 || e_valid !== 1'b0 || exp_q.size() != 0)
      $display("[TB] FAIL ovf_drain: got %0d handshakes valid=%0b pending=%0d expected 5/0/0",
               hs_cnt - hs0, e_valid, exp_q.size());
    else checks_passed++;
  endtask

  task automatic test_full_push_pop();
    int hs0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({3'd4, INFW'(8'h60 + 8'(i))});
      set_ev(3, INFW'(8'h60 + 8'(i)));
      tick();
    end
    clear_ev();
    tick();
    hs0 = hs_cnt;
    exp_q.push_back({3'd4, 8'h65});
    e_ready = 1'b1;
    set_ev(3, 8'h65);
    tick();
    clear_ev();
    checks_total++;
    if (drop_cnt !== 16'd0 || ovf !== 5'b0)
      $display("[TB] FAIL full_push_pop: got cnt=%0d ovf=%05b expected 0/00000", drop_cnt, ovf);
    else checks_passed++;
    wait_drain(20);
    checks_total++;
    if (hs_cnt - hs0 != 6 || exp_q.size() != 0)
      $display("[TB] FAIL full_drain: got %0d handshakes pending=%0d expected 6/0", hs_cnt - hs0, exp_q.size());
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    int hs0;
    do_reset();
    exp_q.push_back({3'd5, 8'hA5});
    exp_q.push_back({3'd5, 8'hA6});
    set_ev(4, 8'hA5);
    tick();
    set_ev(4, 8'hA6);
    tick();
    clear_ev();
    hs0 = hs_cnt;
    for (int s = 0; s < 2; s++) begin
      checks_total++;
      if (e_valid !== 1'b1 || e_id !== 3'd5 || e_info !== 8'hA5)
        $display("[TB] FAIL stall_hold: cycle %0d got v=%0b id=%0d info=%02h expected 1/5/A5",
                 s, e_valid, e_id, e_info);
      else checks_passed++;
      tick();
    end
    e_ready = 1'b1;
    tick();
    e_ready = 1'b0;
    checks_total++;
    if (hs_cnt - hs0 != 1 || e_id !== 3'd5 || e_info !== 8'hA6)
      $display("[TB] FAIL stall_release: got %0d handshakes id=%0d info=%02h expected 1/5/A6",
               hs_cnt - hs0, e_id, e_info);
    else checks_passed++;
    e_ready = 1'b1;
    wait_drain(10);
  endtask

  task automatic test_stats();
    do_reset();
    ev_valid = '1;
    for (int i = 0; i < 8; i++) tick();
    clear_ev();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks_total++;
    if (drop_cnt !== 16'd0 || ovf !== 5'b0)
      $display("[TB] FAIL stats_clear: got cnt=%0d ovf=%05b expected 0/00000", drop_cnt, ovf);
    else checks_passed++;
    ev_valid = 5'b00111;
    tick();
    clear_ev();
    checks_total++;
    if (drop_cnt !== 16'd3 || ovf !== 5'b00111)
      $display("[TB] FAIL stats_multi_drop: got cnt=%0d ovf=%05b expected 3/00111", drop_cnt, ovf);
    else checks_passed++;
    ev_valid  = '1;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    clear_ev();
    checks_total++;
    if (drop_cnt !== 16'd0 || ovf !== 5'b0)
      $display("[TB] FAIL stats_clear_wins: got cnt=%0d ovf=%05b expected 0/00000", drop_cnt, ovf);
    else checks_passed++;
    ev_valid = '1;
    for (int i = 0; i < 13107; i++) tick();
    checks_total++;
    if (drop_cnt !== 16'hFFFF) $display("[TB] FAIL stats_reach_max: got %04h expected FFFF", drop_cnt);
    else checks_passed++;
    tick();
    clear_ev();
    checks_total++;
    if (drop_cnt !== 16'hFFFF || ovf !== 5'b11111)
      $display("[TB] FAIL stats_saturate: got cnt=%04h ovf=%05b expected FFFF/11111", drop_cnt, ovf);
    else checks_passed++;
  endtask

  task automatic test_reset_midflight();
    bit seen;
    do_reset();
    set_ev(0, 8'h71);
    set_ev(1, 8'h72);
    set_ev(2, 8'h73);
    tick();
    clear_ev();
    tick();
    rst = 1'b1;
    tick();
    checks_total++;
    if (e_valid !== 1'b0) $display("[TB] FAIL midflight_reset: got valid=%0b expected 0", e_valid);
    else checks_passed++;
    rst     = 1'b0;
    e_ready = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (e_valid) seen = 1'b1;
    end
    checks_total++;
    if (seen) $display("[TB] FAIL midflight_stale: got stale event expected none");
    else checks_passed++;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    prio_mode = 1'b0;
    e_ready   = 1'b0;
    clr_stats = 1'b0;
    ev_valid  = '0;
    ev_info   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_stats();
    test_reset_midflight();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/spu_event_arbiter.md
Name: spu_event_arbiter

Overview:
- Sits between the SPU AXI channel monitors (AR, AW, R, W, B) and the SPU event output.
- Each monitor raises one-cycle event pulses and cannot be back-pressured, because AXI traffic is never stalled.
- The block buffers events in per-channel FIFOs and serializes them onto one valid/ready event stream using round-robin or fixed-priority arbitration.
- Overflow is counted so no event is silently lost.

Parameters:
- NUM_CH, 5: number of event channels; channel c reports e_id = c+1.
- EVENT_ID_BITS, 3: width of e_id_o; must satisfy 2^EVENT_ID_BITS > NUM_CH.
- EVENT_INFO_BITS, 8: width of the per-event info payload.
- FIFO_DEPTH, 4: entries per channel FIFO; power of two, at least 2.
- DROP_CNT_BITS, 16: width of the saturating drop counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  when 0, incoming pulses are ignored: not stored, not counted as drops.
- prio_mode_i  in  1  0 = round-robin; 1 = fixed priority, lowest channel index wins.
- ev_valid_i  in  NUM_CH  per-channel event pulse.
- ev_info_i  in  NUM_CH*EVENT_INFO_BITS  per-channel payload; channel c occupies bits [c*EVENT_INFO_BITS +: EVENT_INFO_BITS].
- e_valid_o  out  1  output event valid.
- e_ready_i  in  1  downstream accepts the event.
- e_id_o  out  EVENT_ID_BITS  granted channel index + 1.
- e_info_o  out  EVENT_INFO_BITS  payload of the granted event.
- ovf_o  out  NUM_CH  sticky per-channel overflow flags.
- drop_cnt_o  out  DROP_CNT_BITS  saturating total count of dropped events.
- clr_stats_i  in  1  clears ovf_o and drop_cnt_o.

Behaviour:
- Reset (rst_i=1 at an edge) clears the following:
  - all FIFOs to empty;
  - e_valid_o=0, e_id_o=0, e_info_o=0;
  - ovf_o=0, drop_cnt_o=0;
  - round-robin pointer so that channel 0 has top priority.
- Reset mid-transfer discards all buffered events and any held output without handshake.
- Push rule, evaluated per channel:
  - Push when enable_i && ev_valid_i[c].
  - If the FIFO is full and is not popped in the same cycle: the event is dropped, ovf_o[c] is set, drop_cnt_o increments.
  - If the FIFO is full and popped in the same cycle: the push is accepted and nothing is dropped.
- Drops in several channels in the same cycle increment drop_cnt_o by the number of dropping channels. The counter saturates at all-ones and never wraps.
- clr_stats_i in the same cycle as a new drop: the clear wins, and that cycle's drops are not recorded.
- Output register:
  - It loads when it is empty (e_valid_o=0) or being consumed (e_valid_o && e_ready_i).
  - It loads from the arbitration winner among non-empty FIFOs; that FIFO pops in the same cycle.
  - If no FIFO is non-empty, e_valid_o deasserts on the next edge.
- Output stability: while e_valid_o && !e_ready_i, e_id_o and e_info_o stay stable and no FIFO pops.
- Latency:
  - A pulse sampled at edge k into an empty system gives e_valid_o=1 after edge k+1.
  - There is no combinational input-to-output bypass.
- Throughput: one event per cycle while e_ready_i=1 and any FIFO is non-empty.
- Round-robin arbitration:
  - Search starts at (last granted channel + 1) mod NUM_CH.
  - The pointer updates only when an event is loaded.
- Fixed priority: the lowest non-empty channel index wins, and the pointer is left unchanged.
- Switching prio_mode_i takes effect at the next arbitration decision.
- Deasserting enable_i does not flush the FIFOs; buffered events continue to drain.
- Ordering: events from one channel leave in arrival order.

Test Plan:
- Single event: ev_valid_i=5'b00100 with info 0x30 at edge k, e_ready_i=1 → e_valid_o=1, e_id_o=3, e_info_o=0x30 after edge k+1, then e_valid_o=0 after edge k+2.
- Simultaneous events, round-robin, ready held 1:
  - Stimulus: all 5 channels pulse in one cycle, pointer at reset.
  - Required: e_id_o sequence 1,2,3,4,5 on consecutive cycles, then a second burst yields 1,2,3,4,5 again.
  - Repeat with prio_mode_i=1 and a channel 0 pulse injected mid-burst: it preempts the remaining channels.
- Overflow, FIFO_DEPTH=4, e_ready_i=0:
  - Stimulus: 6 pulses on channel 1.
  - Required: ovf_o=5'b00010 and drop_cnt_o=1 (4 in the FIFO, 1 in the output register, 1 dropped).
  - Then e_ready_i=1: exactly 5 events drain, in order.
- Full FIFO with simultaneous push and pop: channel full, e_ready_i=1, new pulse in the same cycle → no drop, drop_cnt_o unchanged.
- Back-pressure stability: e_ready_i toggling 0,0,1 → e_id_o and e_info_o constant across both stalled cycles, with exactly one handshake.
- Stats and reset:
  - drop_cnt_o at all-ones plus one more drop → stays all-ones.
  - clr_stats_i → counter and flags read 0 next cycle.
  - rst_i asserted with 3 events buffered → e_valid_o=0 next cycle and no stale events after release.
